// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state type and counter-width helper for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} rst_seq_state_e;

  function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
    int longest;
    longest = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - reset-release synchroniser: async clear, deassertion shifted in over SyncStages edges
module rst_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_o
);

  logic [SyncStages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign sync_o = sync_q[SyncStages-1];

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staggered reset sequencer; RST_SEQ_SW_REQ_EN enables software re-sequencing
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SyncStages    = 2,
  parameter int HoldCycles    = 4,
  parameter int NumOut        = 3,
  parameter int StaggerCycles = 2,
  parameter int CntWidth      = cnt_width(HoldCycles, StaggerCycles)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NumOut-1:0] rst_no,
  output logic              done_o
);

  if (SyncStages < 2 || HoldCycles < 1 || NumOut < 1 || StaggerCycles < 1 ||
      CntWidth != cnt_width(HoldCycles, StaggerCycles)) begin : g_param_check
    $fatal(1, "rst_seq: illegal parameter set");
  end

  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);
  localparam logic [CntWidth-1:0] StagLast = CntWidth'(StaggerCycles - 1);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

  rst_seq_state_e    state_q;
  logic [CntWidth-1:0] cnt_q;
  logic              sync_rel;
  logic              sw_req;
  logic              hold_fire;
  logic [NumOut-1:0] rel_next;

  rst_sync #(.SyncStages(SyncStages)) u_rst_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sync_o (sync_rel)
  );

`ifdef RST_SEQ_SW_REQ_EN
  assign sw_req = sw_rst_req_i;
`else
  assign sw_req = sw_rst_req_i & 1'b0;
`endif

  // The SYNC exit edge already counts as the first hold cycle.
  assign hold_fire = (state_q == HOLD && cnt_q >= HoldLast) ||
                     (state_q == SYNC && sync_rel && HoldCycles == 1);
  assign rel_next  = (rst_no << 1) | NumOut'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      rst_no  <= '0;
      done_o  <= 1'b0;
    end else if (sw_req && state_q != SYNC) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_no  <= '0;
      done_o  <= 1'b0;
    end else if (hold_fire) begin
      cnt_q  <= '0;
      rst_no <= NumOut'(1);
      if (NumOut == 1) begin
        state_q <= DONE;
        done_o  <= 1'b1;
      end else begin
        state_q <= RELEASE;
      end
    end else begin
      case (state_q)
        SYNC: begin
          if (sync_rel) begin
            state_q <= HOLD;
            cnt_q   <= CntOne;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + CntOne;
        end
        RELEASE: begin
          if (cnt_q >= StagLast) begin
            cnt_q  <= '0;
            rst_no <= rel_next;
            if (&rel_next) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        DONE: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= SYNC;
          cnt_q   <= '0;
          rst_no  <= '0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - scoreboard bench for rst_seq, behaviour follows RST_SEQ_SW_REQ_EN when defined
module tb_rst_seq;

  localparam int S  = 2;
  localparam int H  = 4;
  localparam int N  = 3;
  localparam int ST = 2;
`ifdef RST_SEQ_SW_REQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sw_req;
  logic [N-1:0] rst_o;
  logic         done;
  logic [0:0]   rst1;
  logic         done1;

  always #5 clk = ~clk;

  rst_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sw_rst_req_i (sw_req),
    .rst_no       (rst_o),
    .done_o       (done)
  );

  rst_seq #(.SyncStages(2), .HoldCycles(1), .NumOut(1), .StaggerCycles(2)) dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sw_rst_req_i (1'b0),
    .rst_no       (rst1),
    .done_o       (done1)
  );

  typedef struct {
    logic [N-1:0] r;
    logic         d;
    logic         r1;
    logic         d1;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ecnt, base, rel0, rel1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ecnt, act, req);
    end
  endtask

  // Reference: bit i is released once the edge count reaches the bit-0 release edge plus i staggers.
  function automatic exp_t expect_now();
    exp_t e;
    for (int i = 0; i < N; i++) e.r[i] = rst_n && (ecnt >= rel0 + i * ST);
    e.d  = &e.r;
    e.r1 = rst_n && (ecnt >= rel1);
    e.d1 = e.r1;
    return e;
  endfunction

  task automatic edge_step();
    @(posedge clk);
    ecnt++;
    if (SW_EN && sw_req && rst_n && ecnt > base + S + 1) rel0 = ecnt + H;
  endtask

  task automatic raise_reset();
    rst_n = 1'b1;
    base  = ecnt;
    rel0  = base + S + H;
    rel1  = base + 2 + 1;
  endtask

  function automatic logic [N-1:0] plan_exp(input int e);
    logic [N-1:0] v;
    if (e < 6)       v = 3'b000;
    else if (e < 8)  v = 3'b001;
    else if (e < 10) v = 3'b011;
    else             v = 3'b111;
    if (SW_EN && e >= 20) begin
      if (e < 24)      v = 3'b000;
      else if (e < 26) v = 3'b001;
      else if (e < 28) v = 3'b011;
      else             v = 3'b111;
    end
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_rst_no", 8'(rst_o), 8'(e.r));
        check("sb_done", 8'(done), 8'(e.d));
        check("sb_rst1", 8'(rst1), 8'(e.r1));
        check("sb_done1", 8'(done1), 8'(e.d1));
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] pe;
    rst_n  = 1'b1;
    sw_req = 1'b0;
    ecnt   = 0;
    base   = 0;
    rel0   = 1 << 30;
    rel1   = 1 << 30;
    #1 rst_n = 1'b0;

    repeat (5) begin
      edge_step();
      #2;
      check("pwr_low_rst_no", 8'(rst_o), 8'h00);
      q.push_back(expect_now());
    end
    raise_reset();

    for (int e = 1; e <= 30; e++) begin
      edge_step();
      #2;
      pe = plan_exp(e);
      check("plan_rst_no", 8'(rst_o), 8'(pe));
      check("plan_done", 8'(done), 8'(&pe));
      check("plan_n1", 8'({rst1, done1}), (e >= 3) ? 8'h03 : 8'h00);
      sw_req = (e == 19);
      q.push_back(expect_now());
    end

    repeat (800) begin
      edge_step();
      #2;
      sw_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) sw_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_no", 8'({rst_o, done}), 8'h00);
        check("async_n1", 8'({rst1, done1}), 8'h00);
        q.push_back(expect_now());
        edge_step();
        #2;
        sw_req = 1'b0;
        q.push_back(expect_now());
        #5;
        raise_reset();
      end else begin
        q.push_back(expect_now());
      end
    end

    @(negedge clk);
    #1;
    check("sb_drained", 8'(q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
